layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/layer_scheduler.sv | 128 ++++++++++++
 tb/tb_layer_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// Sequences the CNN stages one at a time: launch a stage, wait for its ready pulse,
// flip the ping-pong buffer, then move on. A per-stage watchdog flags stalled stages.
module layer_scheduler #(
  parameter int NUM_LAYERS = 5,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] ready_i,
  output logic [NUM_LAYERS-1:0] go_o,
  output logic                  buf_sel,
  output logic [2:0]            layer_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [23:0]           cycle_cnt
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SWAP, DONE, ERR} state_t;

  state_t                  state_q;
  logic [NUM_LAYERS-1:0]   go_q;
  logic                    bufSel_q;
  logic [2:0]              layerIdx_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [23:0]             cycleCnt_q;
  logic [23:0]             cycleCnt_d;
  logic [WDW-1:0]          wdog_q;
  logic [2:0]              idxNext;
  logic                    readyHit;
  logic                    lastLayer;
  logic                    wdogExpired;

  always_comb begin
    cycleCnt_d  = cycleCnt_q;
    if (busy_q && (cycleCnt_q != 24'hFFFFFF)) begin
      cycleCnt_d = cycleCnt_q + 24'd1;
    end
    idxNext     = layerIdx_q + 3'd1;
    readyHit    = ready_i[layerIdx_q];
    lastLayer   = (layerIdx_q == 3'(NUM_LAYERS - 1));
    wdogExpired = (wdog_q == WDW'(TIMEOUT - 1));
  end

  // Abort takes priority over everything else; the counter update is overridden
  // by the clear when a new run is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      go_q       <= '0;
      bufSel_q   <= 1'b0;
      layerIdx_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cycleCnt_q <= 24'd0;
      wdog_q     <= '0;
    end else begin
      go_q       <= '0;
      done_q     <= 1'b0;
      cycleCnt_q <= cycleCnt_d;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ERR: begin
            if (start) begin
              state_q    <= ISSUE;
              layerIdx_q <= 3'd0;
              bufSel_q   <= 1'b0;
              cycleCnt_q <= 24'd0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              go_q       <= NUM_LAYERS'(1);
            end
          end
          ISSUE: begin
            state_q <= WAIT;
            wdog_q  <= '0;
          end
          WAIT: begin
            if (readyHit) begin
              state_q <= SWAP;
            end else if (wdogExpired) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
          SWAP: begin
            bufSel_q <= ~bufSel_q;
            if (lastLayer) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              layerIdx_q <= idxNext;
              go_q       <= NUM_LAYERS'(1) << idxNext;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign go_o      = go_q;
  assign buf_sel   = bufSel_q;
  assign layer_idx = layerIdx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cycle_cnt = cycleCnt_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: a per-cycle vector table for one full run,
// then hand sequences for latency, timeout, abort and asynchronous reset.
module tb_layer_scheduler;

  localparam int NL = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NL-1:0] ready_i = '0;
  logic [NL-1:0] go_o;
  logic          buf_sel;
  logic [2:0]    layer_idx;
  logic          busy;
  logic          done;
  logic          err;
  logic [23:0]   cycle_cnt;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;

  typedef struct {
    logic          st;
    logic          ab;
    logic [NL-1:0] rdy;
    logic [NL-1:0] eGo;
    logic          eBusy;
    logic          eDone;
    logic [2:0]    eIdx;
    logic          eSel;
    logic          eErr;
    int            eCnt;
  } vec_t;

  vec_t vecs[20];

  layer_scheduler #(.NUM_LAYERS(NL), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .ready_i(ready_i),
    .go_o(go_o), .buf_sel(buf_sel), .layer_idx(layer_idx), .busy(busy),
    .done(done), .err(err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // done is a one-cycle pulse, so each run that completes adds exactly one here
  always @(negedge clk) begin
    if (done === 1'b1) doneCnt++;
  end

  task automatic applyStimulus(input logic st, input logic ab, input logic [NL-1:0] rdy);
    @(negedge clk);
    start   = st;
    abort   = ab;
    ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int doneBefore;
    logic [NL-1:0] oneHot;

    // st ab rdy | go busy done idx sel err cnt
    vecs[0]  = '{1'b1, 1'b0, 5'h00, 5'h01, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1};
    vecs[2]  = '{1'b0, 1'b0, 5'h01, 5'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b0, 1'b0, 5'h00, 5'h02, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3};
    vecs[4]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 4};
    vecs[5]  = '{1'b0, 1'b0, 5'h02, 5'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 5};
    vecs[6]  = '{1'b0, 1'b0, 5'h00, 5'h04, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 6};
    vecs[7]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 7};
    vecs[8]  = '{1'b0, 1'b0, 5'h01, 5'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 8};
    vecs[9]  = '{1'b0, 1'b0, 5'h1B, 5'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 9};
    vecs[10] = '{1'b0, 1'b0, 5'h04, 5'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 10};
    vecs[11] = '{1'b0, 1'b0, 5'h00, 5'h08, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 11};
    vecs[12] = '{1'b1, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 12};
    vecs[13] = '{1'b0, 1'b0, 5'h08, 5'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 13};
    vecs[14] = '{1'b0, 1'b0, 5'h00, 5'h10, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 14};
    vecs[15] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 15};
    vecs[16] = '{1'b0, 1'b0, 5'h10, 5'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 16};
    vecs[17] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 17};
    vecs[18] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 18};
    vecs[19] = '{1'b0, 1'b0, 5'h1F, 5'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 18};

    #12;
    checkOutput("reset go", 32'(go_o), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    checkOutput("reset idx", 32'(layer_idx), 32'h0);
    checkOutput("reset sel", 32'(buf_sel), 32'h0);
    checkOutput("reset cnt", 32'(cycle_cnt), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] vector table run");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].st, vecs[i].ab, vecs[i].rdy);
      checkOutput($sformatf("v%0d go", i), 32'(go_o), 32'(vecs[i].eGo));
      checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
      checkOutput($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].eDone));
      checkOutput($sformatf("v%0d idx", i), 32'(layer_idx), 32'(vecs[i].eIdx));
      checkOutput($sformatf("v%0d sel", i), 32'(buf_sel), 32'(vecs[i].eSel));
      checkOutput($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].eErr));
      checkOutput($sformatf("v%0d cnt", i), 32'(cycle_cnt), 32'(vecs[i].eCnt));
    end

    // Each ready arrives after ten full idle cycles following the go cycle:
    // 13 cycles per stage plus DONE gives 66. A stray start hits layer 1.
    $display("[TB] nominal run with delayed ready");
    doneBefore = doneCnt;
    applyStimulus(1'b1, 1'b0, '0);
    for (int k = 0; k < NL; k++) begin
      oneHot = NL'(1) << k;
      checkOutput($sformatf("nom go%0d", k), 32'(go_o), 32'(oneHot));
      checkOutput($sformatf("nom idx%0d", k), 32'(layer_idx), k);
      checkOutput($sformatf("nom sel%0d", k), 32'(buf_sel), k % 2);
      for (int i = 0; i < 11; i++) applyStimulus((k == 1) && (i == 4), 1'b0, '0);
      checkOutput($sformatf("nom hold idx%0d", k), 32'(layer_idx), k);
      applyStimulus(1'b0, 1'b0, oneHot);
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkOutput("nom done", 32'(done), 32'h1);
    checkOutput("nom final sel", 32'(buf_sel), 32'h1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("nom cnt", 32'(cycle_cnt), 32'd66);
    checkOutput("nom busy off", 32'(busy), 32'h0);
    checkOutput("nom done count", doneCnt, doneBefore + 1);

    $display("[TB] watchdog timeout");
    doneBefore = doneCnt;
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 5'h1E);
    checkOutput("to pre err", 32'(err), 32'h0);
    checkOutput("to pre busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("to err", 32'(err), 32'h1);
    checkOutput("to busy", 32'(busy), 32'h0);
    checkOutput("to go", 32'(go_o), 32'h0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("to sticky", 32'(err), 32'h1);
    checkOutput("to cnt", 32'(cycle_cnt), 32'd17);
    checkOutput("to no done", doneCnt, doneBefore);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("to restart err", 32'(err), 32'h0);
    checkOutput("to restart go", 32'(go_o), 32'h01);

    $display("[TB] ready on the expiry cycle");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 5'h01);
    checkOutput("race err", 32'(err), 32'h0);
    checkOutput("race busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("race go", 32'(go_o), 32'h02);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("race abort busy", 32'(busy), 32'h0);

    $display("[TB] abort in layer 3 with ready");
    doneBefore = doneCnt;
    applyStimulus(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, NL'(1) << k);
      applyStimulus(1'b0, 1'b0, '0);
    end
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 5'h08);
    checkOutput("ab busy", 32'(busy), 32'h0);
    checkOutput("ab go", 32'(go_o), 32'h0);
    checkOutput("ab idx", 32'(layer_idx), 32'd3);
    checkOutput("ab sel", 32'(buf_sel), 32'h1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("ab still idle", 32'(busy), 32'h0);
    checkOutput("ab sel hold", 32'(buf_sel), 32'h1);
    checkOutput("ab no done", doneCnt, doneBefore);

    $display("[TB] asynchronous reset mid-wait");
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 5'h01);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("ar busy", 32'(busy), 32'h0);
    checkOutput("ar idx", 32'(layer_idx), 32'h0);
    checkOutput("ar sel", 32'(buf_sel), 32'h0);
    checkOutput("ar cnt", 32'(cycle_cnt), 32'h0);
    checkOutput("ar go", 32'(go_o), 32'h0);
    checkOutput("ar err", 32'(err), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'h1F);
    checkOutput("ar stays idle", 32'(busy), 32'h0);

    doneBefore = doneCnt;
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("zl go0", 32'(go_o), 32'h01);
    for (int k = 0; k < NL; k++) begin
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, NL'(1) << k);
      applyStimulus(1'b0, 1'b0, '0);
      if (k < NL - 1) checkOutput($sformatf("zl go%0d", k + 1), 32'(go_o), 32'(NL'(1) << (k + 1)));
    end
    checkOutput("zl done", 32'(done), 32'h1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("zl cnt", 32'(cycle_cnt), 32'd16);
    checkOutput("zl done count", doneCnt, doneBefore + 1);
    checkOutput("zl sel", 32'(buf_sel), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
